digit_scan_driver: RTL and testbench

Parametrised time-multiplexed driver for a common-segment 7-segment display bank. It cycles through `N_DIGITS` digits, activating one digit line at a time for a programmable dwell period. A blanking gap between digits suppresses ghosting. Disabled digits are skipped. It replaces fixed two-digit select logic and sits between the display-content logic (per-digit segment patterns) and the board's digit/segment pins.

---
 rtl/display_pkg.sv | 33 +++
 rtl/digit_next_sel.sv | 28 ++
 rtl/digit_scan_driver.sv | 160 ++++++++++++++++
 tb/tb_digit_scan_driver.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan driver.
// The circular search is written for up to 16 digits and narrowed by callers.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  localparam int          SEG_W      = 7;
  localparam int unsigned MAX_DIGITS = 16;

  // Returns {found, index} of the first set bit in en[0..n-1] at or after idx, wrapping.
  function automatic logic [4:0] next_enabled(input logic [3:0] idx,
                                              input logic [15:0] en,
                                              input int unsigned n);
    logic        found;
    logic [3:0]  sel;
    int unsigned pos;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
      pos = (32'(idx) + k) % n;
      if (k < n && !found && en[pos]) begin
        found = 1'b1;
        sel   = 4'(pos);
      end
    end
    return {found, sel};
  endfunction

endpackage

// File: rtl/digit_next_sel.sv
// Combinational circular finder: first enabled digit at or after start, wrapping.
module digit_next_sel #(
  parameter int N_DIGITS = 4
) (
  input  logic [$clog2(N_DIGITS)-1:0] start,
  input  logic [N_DIGITS-1:0]         en,
  output logic                        found,
  output logic [$clog2(N_DIGITS)-1:0] next_idx
);
  import display_pkg::*;

  localparam int IDX_W = $clog2(N_DIGITS);

  logic [3:0]  start_pad;
  logic [15:0] en_pad;
  logic [4:0]  res;

  always_comb begin
    start_pad              = '0;
    start_pad[IDX_W-1:0]   = start;
    en_pad                 = '0;
    en_pad[N_DIGITS-1:0]   = en;
    res                    = next_enabled(start_pad, en_pad, N_DIGITS);
    found                  = res[4];
    next_idx               = IDX_W'(res[3:0]);
  end

endmodule

// File: rtl/digit_scan_driver.sv
// Time-multiplexed digit scanner: blank gap, then one enabled digit shown per slot.
// Segment data is latched at selection; output polarity is applied only at the output registers.
module digit_scan_driver #(
  parameter int N_DIGITS         = 4,
  parameter int PRESCALE         = 50000,
  parameter int BLANK_CYCLES     = 2,
  parameter int DIGIT_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [7*N_DIGITS-1:0]       seg_data,
  input  logic [N_DIGITS-1:0]         dp_data,
  input  logic [N_DIGITS-1:0]         digit_en,
  output logic [N_DIGITS-1:0]         digit_out,
  output logic [6:0]                  seg_out,
  output logic                        dp_out,
  output logic [$clog2(N_DIGITS)-1:0] scan_idx
);
  import display_pkg::*;

  localparam int IDX_W   = $clog2(N_DIGITS);
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]    SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] DIG_OFF    = (DIGIT_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;
  localparam logic [SEG_W-1:0]    SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : '0;
  localparam logic                DP_OFF     = (SEG_ACTIVE_LOW != 0);

  scan_state_t state, state_nxt;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    start_idx;
  logic [SEG_W-1:0]    lat_seg;
  logic                lat_dp;
  logic                found;
  logic [IDX_W-1:0]    found_idx;
  logic                cnt_clr;
  logic                load_sel;
  logic                start_zero;
  logic                start_adv;
  logic                show_now;
  logic [N_DIGITS-1:0] onehot;

  digit_next_sel #(
    .N_DIGITS(N_DIGITS)
  ) u_next_sel (
    .start   (start_idx),
    .en      (digit_en),
    .found   (found),
    .next_idx(found_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The candidate is re-searched from start_idx at the end of BLANK, so digit_en
  // changes during the gap are honoured while keeping the circular order.
  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b0;
    load_sel   = 1'b0;
    start_zero = 1'b0;
    start_adv  = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt  = BLANK;
          cnt_clr    = 1'b1;
          start_zero = 1'b1;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt_clr = 1'b1;
            if (found) begin
              state_nxt = SHOW;
              load_sel  = 1'b1;
            end
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nxt = BLANK;
            cnt_clr   = 1'b1;
            start_adv = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sel_idx   <= '0;
      start_idx <= '0;
      lat_seg   <= '0;
      lat_dp    <= 1'b0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (start_zero) begin
        start_idx <= '0;
      end else if (start_adv) begin
        start_idx <= (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
      end
      if (load_sel) begin
        sel_idx <= found_idx;
        lat_seg <= seg_data[found_idx*SEG_W +: SEG_W];
        lat_dp  <= dp_data[found_idx];
      end
    end
  end

  assign show_now = (state == SHOW) && enable;

  always_comb begin
    onehot          = '0;
    onehot[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_out <= DIG_OFF;
      seg_out   <= SEG_OFF;
      dp_out    <= DP_OFF;
      scan_idx  <= '0;
    end else if (show_now) begin
      digit_out <= onehot ^ DIG_OFF;
      seg_out   <= lat_seg ^ SEG_OFF;
      dp_out    <= lat_dp ^ DP_OFF;
      scan_idx  <= sel_idx;
    end else begin
      digit_out <= DIG_OFF;
      seg_out   <= SEG_OFF;
      dp_out    <= DP_OFF;
    end
  end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver: run-length vector table, corner sequences and a
// randomized run against a slot-level reference model, on both output polarities.
module tb_digit_scan_driver;

  localparam int N = 4;
  localparam int P = 4;
  localparam int B = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [27:0] seg_data;
  logic [3:0]  dp_data;
  logic [3:0]  digit_en;
  logic [3:0]  dig_a, dig_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [1:0]  idx_a, idx_b;

  always #5 clk = ~clk;

  digit_scan_driver #(
    .N_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B), .DIGIT_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .seg_data(seg_data), .dp_data(dp_data),
    .digit_en(digit_en), .digit_out(dig_a), .seg_out(seg_a), .dp_out(dp_a), .scan_idx(idx_a)
  );

  digit_scan_driver #(
    .N_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B), .DIGIT_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .seg_data(seg_data), .dp_data(dp_data),
    .digit_en(digit_en), .digit_out(dig_b), .seg_out(seg_b), .dp_out(dp_b), .scan_idx(idx_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected pin values for both polarities from an active-high view.
  task automatic check_out(input string tag, input bit vis, input int d,
                           input logic [6:0] pat, input logic dpb);
    logic [3:0] oh, oh_n;
    logic [6:0] sp, sn;
    logic       d1, dn;
    oh = '0;
    if (vis) oh[d[1:0]] = 1'b1;
    sp   = vis ? pat : 7'h00;
    d1   = vis ? dpb : 1'b0;
    oh_n = ~oh;
    sn   = ~sp;
    dn   = ~d1;
    chk({tag, "/digit_lo"}, 32'(dig_a), 32'(oh_n));
    chk({tag, "/seg_lo"},   32'(seg_a), 32'(sn));
    chk({tag, "/dp_lo"},    32'(dp_a),  32'(dn));
    chk({tag, "/digit_hi"}, 32'(dig_b), 32'(oh));
    chk({tag, "/seg_hi"},   32'(seg_b), 32'(sp));
    chk({tag, "/dp_hi"},    32'(dp_b),  32'(d1));
  endtask

  task automatic check_idx(input string tag, input int d);
    chk({tag, "/idx_lo"}, 32'(idx_a), d);
    chk({tag, "/idx_hi"}, 32'(idx_b), d);
  endtask

  typedef struct {
    bit       restart;
    logic [3:0] den;
    int       len;
    int       dig;
  } vec_t;

  vec_t vecs[$];
  logic [6:0] pats[4];

  function automatic void add(input bit r, input logic [3:0] den, input int len, input int dig);
    vec_t v;
    v.restart = r;
    v.den     = den;
    v.len     = len;
    v.dig     = dig;
    vecs.push_back(v);
  endfunction

  // Reference model: slot-level countdowns on plain integers.
  int         ph;
  int         left;
  int         start;
  int         midx;
  logic [6:0] mpat;
  logic       mdp;
  bit         vis;
  int         vidx;
  logic [6:0] vpat;
  logic       vdp;

  task automatic model_reset();
    ph = 0; left = 0; start = 0; midx = 0; mpat = '0; mdp = 1'b0;
    vis = 1'b0; vidx = 0; vpat = '0; vdp = 1'b0;
  endtask

  task automatic model_step();
    int f;
    if (enable && ph == 2) begin
      vis = 1'b1; vidx = midx; vpat = mpat; vdp = mdp;
    end else begin
      vis = 1'b0;
    end
    if (!enable) begin
      ph = 0;
    end else if (ph == 0) begin
      ph = 1; left = B; start = 0;
    end else if (ph == 1) begin
      left--;
      if (left == 0) begin
        f = -1;
        for (int k = 0; k < N; k++)
          if (f < 0 && digit_en[(start + k) % N]) f = (start + k) % N;
        if (f >= 0) begin
          ph = 2; left = P; midx = f; mpat = seg_data[f*7 +: 7]; mdp = dp_data[f];
        end else begin
          left = B;
        end
      end
    end else begin
      left--;
      if (left == 0) begin
        ph = 1; left = B; start = (midx + 1) % N;
      end
    end
  endtask

  task automatic restart_scan(input logic [3:0] den);
    enable   = 1'b0;
    digit_en = den;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b1;
  endtask

  initial begin
    pats[0] = 7'h66; pats[1] = 7'h4F; pats[2] = 7'h5B; pats[3] = 7'h06;

    add(1, 4'hF, 2, -1); add(0, 4'hF, 4, 0); add(0, 4'hF, 1, -1); add(0, 4'hF, 4, 1);
    add(0, 4'hF, 1, -1); add(0, 4'hF, 4, 2); add(0, 4'hF, 1, -1); add(0, 4'hF, 4, 3);
    add(0, 4'hF, 1, -1); add(0, 4'hF, 4, 0);
    add(1, 4'b1010, 2, -1); add(0, 4'b1010, 4, 1); add(0, 4'b1010, 1, -1); add(0, 4'b1010, 4, 3);
    add(0, 4'b1010, 1, -1); add(0, 4'b1010, 4, 1); add(0, 4'b1010, 1, -1); add(0, 4'b1010, 4, 3);
    add(1, 4'b0100, 2, -1); add(0, 4'b0100, 4, 2); add(0, 4'b0100, 1, -1); add(0, 4'b0100, 4, 2);
    add(0, 4'b0100, 1, -1); add(0, 4'b0100, 4, 2);
    add(1, 4'b0000, 12, -1);

    rst_n    = 1'b0;
    enable   = 1'b0;
    seg_data = {7'h06, 7'h5B, 7'h4F, 7'h66};
    dp_data  = 4'b0001;
    digit_en = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 0, 7'h00, 1'b0);
    check_idx("reset", 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].restart) restart_scan(vecs[i].den);
      repeat (vecs[i].len) begin
        @(posedge clk);
        #1;
        if (vecs[i].dig >= 0) begin
          check_out($sformatf("vec%0d", i), 1'b1, vecs[i].dig, pats[vecs[i].dig],
                    dp_data[vecs[i].dig]);
          check_idx($sformatf("vec%0d", i), vecs[i].dig);
        end else begin
          check_out($sformatf("vec%0d", i), 1'b0, 0, 7'h00, 1'b0);
        end
      end
    end

    // Segment data changed mid-slot must wait for the digit's next slot.
    restart_scan(4'hF);
    repeat (3) @(posedge clk);
    #1;
    check_out("latch_pre", 1'b1, 0, 7'h66, 1'b1);
    @(posedge clk);
    #1;
    seg_data[6:0] = 7'h3F;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_out("latch_hold", 1'b1, 0, 7'h66, 1'b1);
    end
    repeat (16) @(posedge clk);
    @(posedge clk);
    #1;
    check_out("latch_next", 1'b1, 0, 7'h3F, 1'b1);
    seg_data[6:0] = 7'h66;

    // Enable dropped while digit 2 is shown, then re-enabled.
    restart_scan(4'hF);
    repeat (14) @(posedge clk);
    #1;
    check_out("drop_pre", 1'b1, 2, 7'h5B, 1'b0);
    enable = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_out("drop_off", 1'b0, 0, 7'h00, 1'b0);
      check_idx("drop_hold", 2);
    end
    enable = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_out("reen_blank", 1'b0, 0, 7'h00, 1'b0);
    end
    @(posedge clk);
    #1;
    check_out("reen_first", 1'b1, 0, 7'h66, 1'b1);
    check_idx("reen_first", 0);

    // Asynchronous reset in the middle of a slot.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 0, 7'h00, 1'b0);
    check_idx("async_rst", 0);
    @(posedge clk);
    #1;
    enable = 1'b0;
    model_reset();
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      if ($urandom_range(0, 7) == 0) digit_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) seg_data = 28'($urandom);
      if ($urandom_range(0, 7) == 0) dp_data = 4'($urandom_range(0, 15));
      @(posedge clk);
      model_step();
      #1;
      check_out("rand", vis, vidx, vpat, vdp);
      check_idx("rand", vidx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
